alu_issue_buffer: RTL

- Two-entry operand buffer between decode and the combinational ALU in the EX stage; it registers operands, ALU opcode and destination tag for each issued instruction.
- Decode-to-ALU handshake is valid/ready, so a stalled EX does not drop or duplicate an instruction.
- While an instruction waits, its stored operands snoop the writeback bus, so a result written back late still reaches it.

---
 rtl/alu_issue_buffer_pkg.sv | 28 ++
 rtl/alu_issue_buffer_if.sv | 40 ++++
 rtl/alu_issue_buffer_issue_entry.sv | 74 +++++++
 rtl/alu_issue_buffer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_issue_buffer_pkg.sv
// Shared constants for the ALU issue buffer: opcode encodings, the zero-register
// tag, the fill-level state type and the illegal-opcode helper.
package alu_issue_buffer_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int REGW_DEFAULT  = 5;

    // Opcode encodings must stay identical to the ALU's own definitions.
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_e;

    function automatic logic is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b00;
    endfunction

endpackage

// File: rtl/alu_issue_buffer_if.sv
// Decode-side, EX-side and writeback-snoop signals of the issue buffer.
interface alu_issue_buffer_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [REGW-1:0]  in_a_tag;
    logic [REGW-1:0]  in_b_tag;
    logic [2:0]       in_alu_op;
    logic [REGW-1:0]  in_dst;

    logic             wb_en;
    logic [REGW-1:0]  wb_reg;
    logic [WIDTH-1:0] wb_data;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [2:0]       out_alu_op;
    logic [REGW-1:0]  out_dst;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_a, in_b, in_a_tag, in_b_tag, in_alu_op, in_dst,
        input  wb_en, wb_reg, wb_data, flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_op, out_dst, out_illegal
    );

    modport master (
        output in_valid, in_a, in_b, in_a_tag, in_b_tag, in_alu_op, in_dst,
        output wb_en, wb_reg, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_op, out_dst, out_illegal
    );

endinterface

// File: rtl/alu_issue_buffer_issue_entry.sv
// One buffered instruction slot: loads a new payload or keeps its own, and in
// either case lets a matching writeback overwrite the A and/or B operand.
module issue_entry
    import alu_issue_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int REGW  = REGW_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             snoop_en,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [REGW-1:0]  src_a_tag,
    input  logic [REGW-1:0]  src_b_tag,
    input  logic [2:0]       src_alu_op,
    input  logic [REGW-1:0]  src_dst,
    input  logic             wb_en,
    input  logic [REGW-1:0]  wb_reg,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [REGW-1:0]  a_tag,
    output logic [REGW-1:0]  b_tag,
    output logic [2:0]       alu_op,
    output logic [REGW-1:0]  dst
);

    logic             update;
    logic             wb_live;
    logic [WIDTH-1:0] base_a;
    logic [WIDTH-1:0] base_b;
    logic [REGW-1:0]  base_a_tag;
    logic [REGW-1:0]  base_b_tag;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    // A loaded payload is snooped as it arrives, so a writeback in the same
    // cycle as the push or shift is never lost.
    always_comb begin
        update     = load | snoop_en;
        wb_live    = wb_en && (wb_reg != REGW'(ZERO_REG));
        base_a     = load ? src_a     : a;
        base_b     = load ? src_b     : b;
        base_a_tag = load ? src_a_tag : a_tag;
        base_b_tag = load ? src_b_tag : b_tag;
        next_a     = (wb_live && base_a_tag == wb_reg) ? wb_data : base_a;
        next_b     = (wb_live && base_b_tag == wb_reg) ? wb_data : base_b;
    end

    // NOTE: the payload is reset as well, because the head slot drives the
    // out_* ports directly and those must read zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a      <= '0;
            b      <= '0;
            a_tag  <= '0;
            b_tag  <= '0;
            alu_op <= '0;
            dst    <= '0;
        end else if (update) begin
            a     <= next_a;
            b     <= next_b;
            a_tag <= base_a_tag;
            b_tag <= base_b_tag;
            if (load) begin
                alu_op <= src_alu_op;
                dst    <= src_dst;
            end
        end
    end

endmodule

// File: rtl/alu_issue_buffer.sv
// Two-entry operand FIFO between decode and the EX-stage ALU. Slot 0 is the head
// and drives the ALU straight from flops; waiting operands snoop writeback.
module alu_issue_buffer
    import alu_issue_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int REGW  = REGW_DEFAULT
) (
    input logic              clock,
    input logic              reset_n,
    alu_issue_buffer_if.slave bus
);

    fill_e state_q;
    fill_e state_d;

    logic       in_ready;
    logic       out_valid;
    logic       push;
    logic       pop;
    logic       shift;
    logic [1:0] load;
    logic [1:0] snoop_en;

    logic [WIDTH-1:0] src_a      [2];
    logic [WIDTH-1:0] src_b      [2];
    logic [REGW-1:0]  src_a_tag  [2];
    logic [REGW-1:0]  src_b_tag  [2];
    logic [2:0]       src_alu_op [2];
    logic [REGW-1:0]  src_dst    [2];

    logic [WIDTH-1:0] slot_a      [2];
    logic [WIDTH-1:0] slot_b      [2];
    logic [REGW-1:0]  slot_a_tag  [2];
    logic [REGW-1:0]  slot_b_tag  [2];
    logic [2:0]       slot_alu_op [2];
    logic [REGW-1:0]  slot_dst    [2];

    // Both handshake flags decode only the fill register, so in_ready never
    // depends on out_ready and nothing from in_* reaches out_* combinationally.
    assign in_ready  = (state_q != FILL_FULL);
    assign out_valid = (state_q != FILL_EMPTY);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments only, and the reset
    // is in the sensitivity list so it takes effect without a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        load    = 2'b00;
        shift   = 1'b0;
        if (bus.flush) begin
            state_d = FILL_EMPTY;
        end else begin
            unique case (state_q)
                FILL_EMPTY: begin
                    if (push) begin
                        load[0] = 1'b1;
                        state_d = FILL_ONE;
                    end
                end
                FILL_ONE: begin
                    if (push && pop) begin
                        load[0] = 1'b1;
                    end else if (push) begin
                        load[1] = 1'b1;
                        state_d = FILL_FULL;
                    end else if (pop) begin
                        state_d = FILL_EMPTY;
                    end
                end
                FILL_FULL: begin
                    if (pop) begin
                        load[0] = 1'b1;
                        shift   = 1'b1;
                        state_d = FILL_ONE;
                    end
                end
                default: state_d = FILL_EMPTY;
            endcase
        end
    end

    // A head leaving this cycle keeps the value the ALU already sampled.
    always_comb begin
        snoop_en[0] = out_valid & ~pop & ~bus.flush;
        snoop_en[1] = (state_q == FILL_FULL) & ~bus.flush;
    end

    always_comb begin
        src_a[1]      = bus.in_a;
        src_b[1]      = bus.in_b;
        src_a_tag[1]  = bus.in_a_tag;
        src_b_tag[1]  = bus.in_b_tag;
        src_alu_op[1] = bus.in_alu_op;
        src_dst[1]    = bus.in_dst;
        src_a[0]      = shift ? slot_a[1]      : bus.in_a;
        src_b[0]      = shift ? slot_b[1]      : bus.in_b;
        src_a_tag[0]  = shift ? slot_a_tag[1]  : bus.in_a_tag;
        src_b_tag[0]  = shift ? slot_b_tag[1]  : bus.in_b_tag;
        src_alu_op[0] = shift ? slot_alu_op[1] : bus.in_alu_op;
        src_dst[0]    = shift ? slot_dst[1]    : bus.in_dst;
    end

    for (genvar k = 0; k < 2; k++) begin : g_slot
        issue_entry #(
            .WIDTH (WIDTH),
            .REGW  (REGW)
        ) u_entry (
            .clock      (clock),
            .reset_n    (reset_n),
            .load       (load[k]),
            .snoop_en   (snoop_en[k]),
            .src_a      (src_a[k]),
            .src_b      (src_b[k]),
            .src_a_tag  (src_a_tag[k]),
            .src_b_tag  (src_b_tag[k]),
            .src_alu_op (src_alu_op[k]),
            .src_dst    (src_dst[k]),
            .wb_en      (bus.wb_en),
            .wb_reg     (bus.wb_reg),
            .wb_data    (bus.wb_data),
            .a          (slot_a[k]),
            .b          (slot_b[k]),
            .a_tag      (slot_a_tag[k]),
            .b_tag      (slot_b_tag[k]),
            .alu_op     (slot_alu_op[k]),
            .dst        (slot_dst[k])
        );
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_a       = slot_a[0];
    assign bus.out_b       = slot_b[0];
    assign bus.out_alu_op  = slot_alu_op[0];
    assign bus.out_dst     = slot_dst[0];
    assign bus.out_illegal = out_valid & is_illegal(slot_alu_op[0]);

endmodule
